ncl_mult3_host_bridge: RTL and testbench

Clocked host-side bridge that sits directly upstream and downstream of the 3x3 NCL multiplier.
- Converts binary operand pairs (valid/ready) into dual-rail DATA/NULL wavefronts on the multiplier's A/B inputs.
- Acts as the multiplier's output consumer: drives its Ki, detects completion of the 6-bit dual-rail product and returns it as binary (valid/ready).
- Adds a watchdog timeout, illegal-code detection and a transaction counter.

---
 rtl/ncl_pkg.sv | 21 ++
 rtl/ncl_sync.sv | 23 ++
 rtl/ncl_mult3_host_bridge.sv | 180 ++++++++++++++++++
 tb/tb_ncl_mult3_host_bridge.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncl_pkg.sv
// Shared types and constants for the NCL 3x3 multiplier host bridge.
package ncl_pkg;

    typedef struct packed {
        logic rail1;
        logic rail0;
    } dual_rail_logic;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_NULL,
        S_ERR
    } bridge_state_e;

    localparam logic [1:0] ERR_NONE         = 2'b00;
    localparam logic [1:0] ERR_DATA_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NULL_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL      = 2'b11;

endpackage

// File: rtl/ncl_sync.sv
// Single-bit synchronizer: STAGES-deep flop chain, cleared by reset.
module ncl_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[STAGES-2:0], d};
        end
    end

    assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/ncl_mult3_host_bridge.sv
// Binary valid/ready <-> dual-rail NCL bridge around a 3x3 NCL multiplier,
// with watchdog, illegal-code trap and completed-transaction counter.
module ncl_mult3_host_bridge
    import ncl_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_a,
    input  logic [2:0]       in_b,
    output logic [2:0]       mult_a_rail1,
    output logic [2:0]       mult_a_rail0,
    output logic [2:0]       mult_b_rail1,
    output logic [2:0]       mult_b_rail0,
    output logic             mult_ki,
    input  logic             mult_ko,
    input  logic [5:0]       prod_rail1,
    input  logic [5:0]       prod_rail0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_p,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] txn_count
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic                 ko_s;
    logic [5:0]           r1_s, r0_s;
    dual_rail_logic [5:0] prod_s;
    logic [5:0]           bit_valid, bit_both, bit_any, p_bin;
    logic [5:0]           both_prev_reg;
    logic                 prod_complete, prod_null, illegal;

    ncl_sync #(.STAGES(SYNC_STAGES)) u_sync_ko (
        .clk(clk), .rst(rst), .d(mult_ko), .q(ko_s)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_prod
            ncl_sync #(.STAGES(SYNC_STAGES)) u_sync_r1 (
                .clk(clk), .rst(rst), .d(prod_rail1[gi]), .q(r1_s[gi])
            );
            ncl_sync #(.STAGES(SYNC_STAGES)) u_sync_r0 (
                .clk(clk), .rst(rst), .d(prod_rail0[gi]), .q(r0_s[gi])
            );
            assign prod_s[gi]    = {r1_s[gi], r0_s[gi]};
            assign bit_valid[gi] = prod_s[gi].rail1 ^ prod_s[gi].rail0;
            assign bit_both[gi]  = prod_s[gi].rail1 & prod_s[gi].rail0;
            assign bit_any[gi]   = prod_s[gi].rail1 | prod_s[gi].rail0;
            assign p_bin[gi]     = prod_s[gi].rail1;
        end
    endgenerate

    // A single both-high sample is tolerated as a synchronizer glitch.
    assign prod_complete = &bit_valid;
    assign prod_null     = ~|bit_any;
    assign illegal       = |(bit_both & both_prev_reg);

    bridge_state_e    state_reg, state_next;
    logic [WD_W-1:0]  wd_reg, wd_next;
    logic [2:0]       a_reg, a_next, b_reg, b_next;
    logic [2:0]       a1_next, a0_next, b1_next, b0_next;
    logic             ki_next, in_ready_next, out_valid_next, err_next;
    logic [1:0]       err_code_next;
    logic [5:0]       out_p_next;
    logic [CNT_W-1:0] txn_count_next;
    logic             accept, capture, retire;

    always_comb begin
        state_next    = state_reg;
        err_code_next = err_code;
        accept        = 1'b0;
        capture       = 1'b0;
        retire        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    accept     = 1'b1;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (prod_complete && !ko_s) begin
                    capture    = 1'b1;
                    state_next = S_NULL;
                end else if (wd_reg == WD_LAST) begin
                    state_next    = S_ERR;
                    err_code_next = ERR_DATA_TIMEOUT;
                end
            end
            S_NULL: begin
                if (prod_null && ko_s) begin
                    retire     = 1'b1;
                    state_next = S_IDLE;
                end else if (wd_reg == WD_LAST) begin
                    state_next    = S_ERR;
                    err_code_next = ERR_NULL_TIMEOUT;
                end
            end
            default: ;
        endcase
        // Illegal codes override any handshake progress made this cycle.
        if (illegal && state_reg != S_ERR) begin
            accept        = 1'b0;
            capture       = 1'b0;
            retire        = 1'b0;
            state_next    = S_ERR;
            err_code_next = ERR_ILLEGAL;
        end

        err_next = err | (state_next == S_ERR);
        if (state_next != state_reg) begin
            wd_next = '0;
        end else if (state_reg == S_DATA || state_reg == S_NULL) begin
            wd_next = wd_reg + 1'b1;
        end else begin
            wd_next = wd_reg;
        end

        a_next         = accept ? in_a : a_reg;
        b_next         = accept ? in_b : b_reg;
        a1_next        = (state_next == S_DATA) ? a_next : 3'b000;
        a0_next        = (state_next == S_DATA) ? ~a_next : 3'b000;
        b1_next        = (state_next == S_DATA) ? b_next : 3'b000;
        b0_next        = (state_next == S_DATA) ? ~b_next : 3'b000;
        ki_next        = (state_next == S_IDLE) || (state_next == S_DATA);
        out_p_next     = capture ? p_bin : out_p;
        out_valid_next = capture ? 1'b1 : (out_valid && !out_ready);
        txn_count_next = retire ? txn_count + 1'b1 : txn_count;
        in_ready_next  = (state_next == S_IDLE) && ko_s && !out_valid_next && !err_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            wd_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            both_prev_reg <= '0;
            mult_a_rail1  <= '0;
            mult_a_rail0  <= '0;
            mult_b_rail1  <= '0;
            mult_b_rail0  <= '0;
            mult_ki       <= 1'b1;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            out_p         <= '0;
            err           <= 1'b0;
            err_code      <= ERR_NONE;
            txn_count     <= '0;
        end else begin
            state_reg     <= state_next;
            wd_reg        <= wd_next;
            a_reg         <= a_next;
            b_reg         <= b_next;
            both_prev_reg <= bit_both;
            mult_a_rail1  <= a1_next;
            mult_a_rail0  <= a0_next;
            mult_b_rail1  <= b1_next;
            mult_b_rail0  <= b0_next;
            mult_ki       <= ki_next;
            in_ready      <= in_ready_next;
            out_valid     <= out_valid_next;
            out_p         <= out_p_next;
            err           <= err_next;
            err_code      <= err_code_next;
            txn_count     <= txn_count_next;
        end
    end

endmodule

// File: tb/tb_ncl_mult3_host_bridge.sv
// Scenario bench for the NCL host bridge with a behavioural multiplier model.
module tb_ncl_mult3_host_bridge;

    localparam int SYNC     = 2;
    localparam int TMO      = 16;
    localparam int CW       = 3;
    localparam int DELAY    = 3;
    localparam int M_NORMAL = 0;
    localparam int M_NODATA = 1;
    localparam int M_NONULL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_ready;
    logic [2:0]    in_a = '0, in_b = '0;
    logic [2:0]    mult_a_rail1, mult_a_rail0, mult_b_rail1, mult_b_rail0;
    logic          mult_ki, mult_ko;
    logic [5:0]    prod_rail1, prod_rail0;
    logic          out_valid, out_ready = 1'b0;
    logic [5:0]    out_p;
    logic          err;
    logic [1:0]    err_code;
    logic [CW-1:0] txn_count;

    logic          m_ko = 1'b1;
    logic [5:0]    m_p1 = '0, m_p0 = '0, inj1 = '0, inj0 = '0;
    int            m_cnt = 0;
    int            mode = M_NORMAL;
    logic [5:0]    exp_q[$];
    int            vectors = 0;
    int            miscompares = 0;

    assign mult_ko    = m_ko;
    assign prod_rail1 = m_p1 | inj1;
    assign prod_rail0 = m_p0 | inj0;

    always #5 clk = ~clk;

    ncl_mult3_host_bridge #(
        .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .mult_a_rail1(mult_a_rail1), .mult_a_rail0(mult_a_rail0),
        .mult_b_rail1(mult_b_rail1), .mult_b_rail0(mult_b_rail0),
        .mult_ki(mult_ki), .mult_ko(mult_ko),
        .prod_rail1(prod_rail1), .prod_rail0(prod_rail0),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .err(err), .err_code(err_code), .txn_count(txn_count)
    );

    // Behavioural NCL multiplier: DATA after DELAY cycles once inputs are DATA and Ki=1,
    // NULL after DELAY cycles once inputs are NULL and Ki=0.
    always @(negedge clk or posedge rst) begin
        logic       in_data, in_null;
        logic [5:0] prod;
        if (rst) begin
            m_cnt = 0; m_p1 = '0; m_p0 = '0; m_ko = 1'b1;
        end else begin
            in_data = (&(mult_a_rail1 ^ mult_a_rail0)) && (&(mult_b_rail1 ^ mult_b_rail0));
            in_null = ~|{mult_a_rail1, mult_a_rail0, mult_b_rail1, mult_b_rail0};
            if (m_ko && mult_ki && in_data && mode != M_NODATA) begin
                m_cnt++;
                if (m_cnt >= DELAY) begin
                    prod = {3'b000, mult_a_rail1} * {3'b000, mult_b_rail1};
                    m_p1 = prod; m_p0 = ~prod; m_ko = 1'b0; m_cnt = 0;
                end
            end else if (!m_ko && !mult_ki && in_null && mode != M_NONULL) begin
                m_cnt++;
                if (m_cnt >= DELAY) begin
                    m_p1 = '0; m_p0 = '0; m_ko = 1'b1; m_cnt = 0;
                end
            end else begin
                m_cnt = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        inj1 = '0; inj0 = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [2:0] a, input logic [2:0] b);
        int t = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            vectors++; miscompares++;
            $display("FAIL send_wait: in_ready=%b required 1 within 200 cycles", in_ready);
        end else begin
            in_a = a; in_b = b; in_valid = 1'b1;
            exp_q.push_back({3'b000, a} * {3'b000, b});
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic recv(input string name);
        int t = 0;
        logic [5:0] e;
        @(negedge clk);
        while (out_valid !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (t >= 300) begin
            miscompares++;
            $display("FAIL %s_timeout: out_valid=%b required 1", name, out_valid);
        end else if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s_unexpected: out_p=%0d with no pending operands", name, out_p);
        end else begin
            e = exp_q.pop_front();
            $display("txn %s: out_p=%0d expected=%0d", name, out_p, e);
            if (out_p !== e) begin
                miscompares++;
                $display("FAIL %s_product: got %0d required %0d", name, out_p, e);
            end
            if (out_ready) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (t >= 200) begin
            miscompares++;
            $display("FAIL %s_idle: in_ready=%b required 1", name, in_ready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({mult_a_rail1, mult_a_rail0, mult_b_rail1, mult_b_rail0} !== 12'h000 || mult_ki !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_rails: rails=%h ki=%b required 000/1",
                     {mult_a_rail1, mult_a_rail0, mult_b_rail1, mult_b_rail0}, mult_ki);
        end
        vectors++;
        if ({in_ready, out_valid, out_p, err, err_code, txn_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: rdy=%b ov=%b p=%0d err=%b code=%0d cnt=%0d required all 0",
                     in_ready, out_valid, out_p, err, err_code, txn_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        mode = M_NORMAL;
        out_ready = 1'b1;
        send(3'd5, 3'd7);
        recv("basic_5x7");
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_single_valid: out_valid=%b required 0", out_valid);
        end
        wait_idle("basic");
        vectors++;
        if (txn_count !== 3'd1 || mult_ki !== 1'b1 ||
            {mult_a_rail1, mult_a_rail0, mult_b_rail1, mult_b_rail0} !== 12'h000) begin
            miscompares++;
            $display("FAIL basic_after: cnt=%0d ki=%b rails=%h required 1/1/000", txn_count, mult_ki,
                     {mult_a_rail1, mult_a_rail0, mult_b_rail1, mult_b_rail0});
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send(3'd7, 3'd7);
        recv("b2b_7x7");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (out_p !== 6'd49 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_hold[%0d]: p=%0d ov=%b rdy=%b required 49/1/0", i, out_p, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_pop: out_valid=%b required 0", out_valid);
        end
        send(3'd0, 3'd0);
        recv("b2b_0x0");
    endtask

    task automatic test_data_timeout();
        mode = M_NODATA;
        do_reset();
        send(3'd1, 3'd1);
        repeat (TMO - 1) @(posedge clk);
        #1;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL data_tmo_early: err=%b required 0", err);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (err !== 1'b1 || err_code !== 2'b01) begin
            miscompares++;
            $display("FAIL data_tmo: err=%b code=%b required 1/01", err, err_code);
        end
        mode = M_NORMAL;
        repeat (10) @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || {mult_a_rail1, mult_a_rail0, mult_b_rail1, mult_b_rail0} !== 12'h000) begin
            miscompares++;
            $display("FAIL data_tmo_stuck: rdy=%b rails=%h required 0/000", in_ready,
                     {mult_a_rail1, mult_a_rail0, mult_b_rail1, mult_b_rail0});
        end
        exp_q.delete();
    endtask

    task automatic test_null_timeout();
        int t = 0;
        mode = M_NONULL;
        do_reset();
        out_ready = 1'b1;
        send(3'd2, 3'd2);
        recv("null_tmo_2x2");
        while (err !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (err !== 1'b1 || err_code !== 2'b10) begin
            miscompares++;
            $display("FAIL null_tmo: err=%b code=%b required 1/10", err, err_code);
        end
        mode = M_NORMAL;
        do_reset();
        vectors++;
        if (err !== 1'b0 || err_code !== 2'b00) begin
            miscompares++;
            $display("FAIL null_tmo_clear: err=%b code=%b required 0/00", err, err_code);
        end
        wait_idle("null_tmo_recover");
    endtask

    task automatic test_glitch_illegal();
        int t = 0;
        mode = M_NORMAL;
        do_reset();
        wait_idle("glitch_pre");
        inj1 = 6'b000100; inj0 = 6'b000100;
        @(negedge clk);
        inj1 = '0; inj0 = '0;
        repeat (8) @(negedge clk);
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_no_err: err=%b code=%b required 0", err, err_code);
        end
        out_ready = 1'b1;
        send(3'd2, 3'd3);
        recv("glitch_2x3");
        wait_idle("glitch_post");
        inj1 = 6'b000100; inj0 = 6'b000100;
        repeat (3) @(negedge clk);
        inj1 = '0; inj0 = '0;
        while (err !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (err !== 1'b1 || err_code !== 2'b11) begin
            miscompares++;
            $display("FAIL illegal: err=%b code=%b required 1/11", err, err_code);
        end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        mode = M_NORMAL;
        do_reset();
        out_ready = 1'b1;
        send(3'd3, 3'd6);
        @(negedge clk);
        vectors++;
        if ({mult_a_rail1, mult_a_rail0, mult_b_rail1, mult_b_rail0} !== {3'd3, 3'd4, 3'd6, 3'd1}) begin
            miscompares++;
            $display("FAIL mid_data_rails: rails=%h required %h",
                     {mult_a_rail1, mult_a_rail0, mult_b_rail1, mult_b_rail0}, {3'd3, 3'd4, 3'd6, 3'd1});
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({mult_a_rail1, mult_a_rail0, mult_b_rail1, mult_b_rail0} !== 12'h000 || mult_ki !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_rst_async: rails=%h ki=%b required 000/1",
                     {mult_a_rail1, mult_a_rail0, mult_b_rail1, mult_b_rail0}, mult_ki);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0 || txn_count !== 3'd0) begin
            miscompares++;
            $display("FAIL mid_rst_discard: seen_valid=%b cnt=%0d required 0/0", seen, txn_count);
        end
        send(3'd3, 3'd6);
        recv("mid_3x6");
    endtask

    task automatic test_wrap();
        logic [2:0] a, b;
        logic [CW-1:0] want;
        mode = M_NORMAL;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            a = 3'($urandom_range(0, 7));
            b = 3'($urandom_range(0, 7));
            send(a, b);
            recv("wrap");
            wait_idle("wrap");
            want = CW'(i + 1);
            vectors++;
            if (txn_count !== want) begin
                miscompares++;
                $display("FAIL wrap_count[%0d]: got %0d required %0d", i, txn_count, want);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_data_timeout();
        test_null_timeout();
        test_glitch_illegal();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
